// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared seven-segment constants and digit-count helpers
package seg7_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic int num_digits(input int data_w);
    return data_w / 4;
  endfunction

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational nibble to active-low seven-segment pattern
module hex_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/out_unit_seg7_scanner.sv
// rtl/out_unit_seg7_scanner.sv - multiplexed hex display of the CPU OUT word with halt flag and change pulse
module out_unit_seg7_scanner
  import seg7_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int REFRESH_DIV = 50000,
  localparam int NUM_DIGITS = num_digits(DATA_W)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     out_data,
  input  logic                  run,
  input  logic                  blank_lz,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  changed
);

  localparam int IDX_W = idx_width(NUM_DIGITS);
  localparam int CNT_W = $clog2(REFRESH_DIV);

  logic [DATA_W-1:0]     disp_q, disp_d;
  logic                  changed_q, changed_d;
  logic [CNT_W-1:0]      div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]      digit_idx_q, digit_idx_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  dp_q, dp_d;

  logic [3:0] cur_nibble;
  logic [6:0] cur_pattern;
  logic       cur_blank;

  hex_to_seg7 u_hex_to_seg7 (
    .nibble (cur_nibble),
    .seg    (cur_pattern)
  );

  // A digit is a leading zero when it and every more significant nibble are zero
  assign cur_nibble = disp_q[{digit_idx_q, 2'b00} +: 4];
  assign cur_blank  = blank_lz && (digit_idx_q != '0) &&
                      ((disp_q >> {digit_idx_q, 2'b00}) == '0);

  always_comb begin
    disp_d      = disp_q;
    changed_d   = 1'b0;
    div_cnt_d   = div_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;

    if (run) begin
      disp_d    = out_data;
      changed_d = (out_data != disp_q);
    end

    if (div_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
      div_cnt_d = '0;
      if (digit_idx_q == IDX_W'(NUM_DIGITS - 1)) begin
        digit_idx_d = '0;
      end else begin
        digit_idx_d = digit_idx_q + 1'b1;
      end
    end

    an_d  = ~(NUM_DIGITS'(1) << digit_idx_q);
    seg_d = cur_blank ? SEG_BLANK : cur_pattern;
    dp_d  = !((digit_idx_q == '0) && !run);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      disp_q      <= '0;
      changed_q   <= 1'b0;
      div_cnt_q   <= '0;
      digit_idx_q <= '0;
      an_q        <= '1;
      seg_q       <= SEG_BLANK;
      dp_q        <= 1'b1;
    end else begin
      disp_q      <= disp_d;
      changed_q   <= changed_d;
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
      dp_q        <= dp_d;
    end
  end

  assign an      = an_q;
  assign seg     = seg_q;
  assign dp      = dp_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_out_unit_seg7_scanner.sv
// tb/tb_out_unit_seg7_scanner.sv - randomized bench against a slot-arithmetic display model
module tb_out_unit_seg7_scanner;

  localparam int DATA_W = 32;
  localparam int DIV    = 4;
  localparam int ND     = DATA_W / 4;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] out_data = '0;
  logic              run = 1'b1;
  logic              blank_lz = 1'b0;
  logic [ND-1:0]     an;
  logic [6:0]        seg;
  logic              dp;
  logic              changed;

  int n_cmp = 0;
  int n_bad = 0;

  // Model state: edges since reset release and the value the display holds
  int          m_t = 0;
  logic [31:0] m_disp = '0;
  int          last_idx = 0;

  out_unit_seg7_scanner #(.DATA_W(DATA_W), .REFRESH_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .out_data (out_data),
    .run      (run),
    .blank_lz (blank_lz),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] hex_glyph(input int v);
    case (v)
      0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
      4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
      8: return 7'h00;  9: return 7'h10; 10: return 7'h08; 11: return 7'h03;
     12: return 7'h46; 13: return 7'h21; 14: return 7'h06; default: return 7'h0E;
    endcase
  endfunction

  // Apply inputs, predict what the next edge shows, advance one clock and compare
  task automatic step(input logic [31:0] d, input logic r, input logic b);
    int idx;
    logic [31:0] upper;
    logic [6:0] e_seg;
    logic [7:0] e_an;
    logic e_dp, e_chg;
    out_data = d;
    run      = r;
    blank_lz = b;
    idx   = (m_t / DIV) % ND;
    upper = m_disp >> (4 * idx);
    e_an  = ~(8'd1 << idx);
    e_seg = (b && idx > 0 && upper == 0) ? 7'h7F : hex_glyph(int'(upper % 16));
    e_dp  = !(idx == 0 && !r);
    e_chg = r && (d != m_disp);
    if (r) m_disp = d;
    m_t++;
    last_idx = idx;
    @(posedge clk);
    #1;
    check_eq("an", 32'(an), 32'(e_an));
    check_eq("seg", 32'(seg), 32'(e_seg));
    check_eq("dp", 32'(dp), 32'(e_dp));
    check_eq("changed", 32'(changed), 32'(e_chg));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_an"}, 32'(an), 32'hFF);
    check_eq({tag, "_seg"}, 32'(seg), 32'h7F);
    check_eq({tag, "_dp"}, 32'(dp), 32'h1);
    check_eq({tag, "_changed"}, 32'(changed), 32'h0);
  endtask

  initial begin
    logic [31:0] d;
    logic r, b;
    int guard;

    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    reset = 1'b1;
    m_t = 0;
    m_disp = '0;

    repeat (8) step(32'h0, 1'b1, 1'b0);
    repeat (40) step(32'h1234ABCF, 1'b1, 1'b0);
    repeat (40) step(32'h000000A5, 1'b1, 1'b1);
    repeat (40) step(32'hDEADBEEF, 1'b0, 1'b0);
    repeat (40) step(32'hDEADBEEF, 1'b1, 1'b0);
    repeat (20) step(32'h0, 1'b1, 1'b1);

    d = 32'h0;
    b = 1'b0;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 3))
        0: d = d;
        1: d = $urandom;
        2: d = $urandom & (32'hFFFF_FFFF >> (4 * $urandom_range(1, 7)));
        default: d = 32'h0;
      endcase
      r = ($urandom_range(0, 3) != 0);
      if (i % 16 == 0) b = 1'($urandom_range(0, 1));
      step(d, r, b);
    end

    // Land in a digit-5 slot, then pull reset between clock edges
    guard = 0;
    while (last_idx != 5 && guard < 64) begin
      step(32'h89ABCDEF, 1'b1, 1'b0);
      guard++;
    end
    check_eq("reach_digit5", 32'(last_idx), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(posedge clk);
    #1;
    check_reset_outputs("held_rst");
    @(negedge clk);
    reset = 1'b1;
    m_t = 0;
    m_disp = '0;
    repeat (40) step(32'h00C0FFEE, 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
